// File: rtl/dac_pkg.sv
// Shared DAC definitions: AD5310-style frame geometry, power-down codes,
// serializer state encoding and sample-format helpers.
package dac_pkg;

   localparam int DAC_FRAME_W = 16;
   localparam int DAC_DATA_W  = 10;

   // Field offsets inside the 16-bit serial frame
   localparam int PD_LSB   = 12;
   localparam int DATA_LSB = 2;

   // Power-down encodings (PD1/PD0)
   localparam logic [1:0] PD_NORMAL    = 2'b00;
   localparam logic [1:0] PD_1K_GND    = 2'b01;
   localparam logic [1:0] PD_100K_GND  = 2'b10;
   localparam logic [1:0] PD_TRISTATE  = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      TAIL  = 2'd2,
      GAP   = 2'd3
   } dac_state_e;

   // Two's complement to offset binary: flipping the sign bit maps -512..511 onto 0..1023
   function automatic logic [DAC_DATA_W-1:0] to_offset_bin(input logic [DAC_DATA_W-1:0] s);
      return {~s[DAC_DATA_W-1], s[DAC_DATA_W-2:0]};
   endfunction

   // Assemble {00, pd, code, 00}
   function automatic logic [DAC_FRAME_W-1:0] build_frame(input logic [DAC_DATA_W-1:0] s,
                                                          input logic [1:0]            pd_bits);
      logic [DAC_FRAME_W-1:0] f;
      f = '0;
      f[PD_LSB +: 2]            = pd_bits;
      f[DATA_LSB +: DAC_DATA_W] = to_offset_bin(s);
      return f;
   endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider; emits a one-cycle tick every SAMPLE_DIV
// clocks. Shared between the DAC and ADC paths.
module sample_tick_gen #(
   parameter int SAMPLE_DIV = 100
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int               CNT_W = $clog2(SAMPLE_DIV);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(SAMPLE_DIV - 1);

   logic [CNT_W-1:0] count;

   // Count 0..SAMPLE_DIV-1 and wrap; never gated by anything downstream
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (count == LAST)
         count <= '0;
      else
         count <= count + 1'b1;
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/dds_dac_spi.sv
// Samples the DDS sine at a fixed rate, converts to offset binary and ships
// each sample to an AD5310-style DAC as a 16-bit MSB-first SPI frame.
// All outputs come straight from flops so the DAC pins never glitch.
module dds_dac_spi
   import dac_pkg::*;
#(
   parameter int CLK_DIV    = 2,
   parameter int SAMPLE_DIV = 100
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [DAC_DATA_W-1:0] sample_in,
   input  logic [1:0]            pd,
   output logic                  dac_sync_n,
   output logic                  dac_sclk,
   output logic                  dac_din,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  overrun
);

   // One counter serves the SCLK half periods, the tail and the 2*CLK_DIV gap
   localparam int            CW        = $clog2(2 * CLK_DIV + 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(2 * CLK_DIV - 1);

   logic tick;

   sample_tick_gen #(
      .SAMPLE_DIV(SAMPLE_DIV)
   ) u_tick (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick)
   );

   dac_state_e             state, state_nxt;
   logic [CW-1:0]          cnt, cnt_nxt;
   logic [3:0]             bit_cnt, bit_cnt_nxt;
   logic                   phase_lo, phase_lo_nxt;
   logic [DAC_FRAME_W-1:0] shreg, shreg_nxt;
   logic [DAC_FRAME_W-1:0] frame;
   logic                   sync_n_nxt, sclk_nxt, din_nxt, busy_nxt, done_nxt, ovr_nxt;

   assign frame = build_frame(sample_in, pd);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state plus next values of every counter and output flop
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      bit_cnt_nxt  = bit_cnt;
      phase_lo_nxt = phase_lo;
      shreg_nxt    = shreg;
      sync_n_nxt   = dac_sync_n;
      sclk_nxt     = dac_sclk;
      din_nxt      = dac_din;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      ovr_nxt      = 1'b0;

      unique case (state)
         IDLE: begin
            if (tick && enable) begin
               state_nxt    = SHIFT;
               shreg_nxt    = frame;
               cnt_nxt      = '0;
               bit_cnt_nxt  = '0;
               phase_lo_nxt = 1'b0;
               sync_n_nxt   = 1'b0;
               sclk_nxt     = 1'b1;
               din_nxt      = frame[DAC_FRAME_W-1];
               busy_nxt     = 1'b1;
            end
         end

         SHIFT: begin
            if (cnt == HALF_LAST) begin
               cnt_nxt = '0;
               if (!phase_lo) begin
                  // High half done: SCLK falls, DAC latches the current bit
                  phase_lo_nxt = 1'b1;
                  sclk_nxt     = 1'b0;
               end else if (bit_cnt == 4'd15) begin
                  state_nxt    = TAIL;
                  phase_lo_nxt = 1'b0;
                  sclk_nxt     = 1'b1;
                  din_nxt      = 1'b0;
               end else begin
                  // Next bit appears together with the SCLK rising edge
                  bit_cnt_nxt  = bit_cnt + 4'd1;
                  shreg_nxt    = {shreg[DAC_FRAME_W-2:0], 1'b0};
                  din_nxt      = shreg[DAC_FRAME_W-2];
                  sclk_nxt     = 1'b1;
                  phase_lo_nxt = 1'b0;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         TAIL: begin
            if (cnt == HALF_LAST) begin
               cnt_nxt    = '0;
               state_nxt  = GAP;
               sync_n_nxt = 1'b1;
               done_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         GAP: begin
            if (cnt == GAP_LAST) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         default: state_nxt = IDLE;
      endcase

      // A tick that arrives while a frame is in flight is dropped, not queued
      if (tick && enable && (state != IDLE))
         ovr_nxt = 1'b1;
   end

   // Datapath and output flops; reset abandons any partial frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         bit_cnt    <= '0;
         phase_lo   <= 1'b0;
         shreg      <= '0;
         dac_sync_n <= 1'b1;
         dac_sclk   <= 1'b1;
         dac_din    <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         bit_cnt    <= bit_cnt_nxt;
         phase_lo   <= phase_lo_nxt;
         shreg      <= shreg_nxt;
         dac_sync_n <= sync_n_nxt;
         dac_sclk   <= sclk_nxt;
         dac_din    <= din_nxt;
         busy       <= busy_nxt;
         frame_done <= done_nxt;
         overrun    <= ovr_nxt;
      end
   end

endmodule

// File: tb/tb_dds_dac_spi.sv
// Directed bench for dds_dac_spi: frame contents, SYNC/busy timing, streaming
// cadence, enable gating, mid-frame reset and overrun on a second instance.
module tb_dds_dac_spi;

   localparam int CD   = 2;
   localparam int SD   = 100;
   localparam int SD_B = 50;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic [9:0] sample_in = '0;
   logic [1:0] pd = '0;
   logic       enable_b = 1'b1;
   logic [9:0] sample_b = 10'h155;
   logic [1:0] pd_b = 2'b10;

   logic a_sync_n, a_sclk, a_din, a_busy, a_done, a_ovr;
   logic b_sync_n, b_sclk, b_din, b_busy, b_done, b_ovr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dds_dac_spi #(.CLK_DIV(CD), .SAMPLE_DIV(SD)) dut_a (
      .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in), .pd(pd),
      .dac_sync_n(a_sync_n), .dac_sclk(a_sclk), .dac_din(a_din),
      .busy(a_busy), .frame_done(a_done), .overrun(a_ovr)
   );

   dds_dac_spi #(.CLK_DIV(CD), .SAMPLE_DIV(SD_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .enable(enable_b), .sample_in(sample_b), .pd(pd_b),
      .dac_sync_n(b_sync_n), .dac_sclk(b_sclk), .dac_din(b_din),
      .busy(b_busy), .frame_done(b_done), .overrun(b_ovr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- SPI monitors (sampled on the falling clk edge) -------------
   int cyc = 0;
   logic a_prev_sync = 1'b1, a_prev_sclk = 1'b1, a_prev_busy = 1'b0;
   logic [15:0] a_sh = '0, a_word = '0;
   int a_nb = 0, a_nbits = 0, a_sync_run = 0, a_busy_run = 0;
   int a_sync_len = 0, a_busy_len = 0, a_n_start = 0, a_n_end = 0;
   int a_n_done = 0, a_n_ovr = 0, a_start_cyc = 0, a_prev_start_cyc = 0;
   logic b_prev_sync = 1'b1, b_prev_sclk = 1'b1;
   logic [15:0] b_sh = '0, b_word = '0;
   int b_n_start = 0, b_n_ovr = 0, b_start_cyc = 0, b_prev_start_cyc = 0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      // DUT A
      if (a_prev_sync && !a_sync_n) begin
         a_sh = '0; a_nb = 0; a_sync_run = 0;
         a_prev_start_cyc = a_start_cyc; a_start_cyc = cyc; a_n_start++;
      end
      if (!a_prev_busy && a_busy) a_busy_run = 0;
      if (!a_sync_n) a_sync_run++;
      if (a_busy) a_busy_run++;
      if (a_prev_sclk && !a_sclk && !a_sync_n) begin
         a_sh = {a_sh[14:0], a_din}; a_nb++;
      end
      if (!a_prev_sync && a_sync_n) begin
         a_word = a_sh; a_nbits = a_nb; a_sync_len = a_sync_run; a_n_end++;
      end
      if (a_prev_busy && !a_busy) a_busy_len = a_busy_run;
      if (a_done) a_n_done++;
      if (a_ovr) a_n_ovr++;
      a_prev_sync = a_sync_n; a_prev_sclk = a_sclk; a_prev_busy = a_busy;
      // DUT B
      if (b_prev_sync && !b_sync_n) begin
         b_sh = '0; b_prev_start_cyc = b_start_cyc; b_start_cyc = cyc; b_n_start++;
      end
      if (b_prev_sclk && !b_sclk && !b_sync_n) b_sh = {b_sh[14:0], b_din};
      if (!b_prev_sync && b_sync_n) b_word = b_sh;
      if (b_ovr) b_n_ovr++;
      b_prev_sync = b_sync_n; b_prev_sclk = b_sclk;
   end

   // ---------------- driver / wait helpers ----------------
   task automatic wait_start(input int target);
      int k;
      k = 0;
      while (a_n_start < target && k < 400) begin
         @(negedge clk); #1; k++;
      end
      check("wait_start", a_n_start, target);
   endtask

   task automatic wait_end(input int target);
      int k;
      k = 0;
      while (a_n_end < target && k < 400) begin
         @(negedge clk); #1; k++;
      end
      check("wait_end", a_n_end, target);
   endtask

   task automatic cycles_to_start(output int n);
      n = 0;
      while (a_sync_n && n < 300) begin
         @(posedge clk); #1; n++;
      end
   endtask

   // Directed stream: sample, pd, expected decoded frame
   logic [9:0]  v_s [7] = '{10'h000, 10'h1FF, 10'h200, 10'h3FF, 10'h07F, 10'h380, 10'h2AA};
   logic [1:0]  v_p [7] = '{2'b00,   2'b00,   2'b11,   2'b01,   2'b00,   2'b10,   2'b00};
   logic [15:0] v_w [7] = '{16'h0800, 16'h0FFC, 16'h3000, 16'h17FC, 16'h09FC, 16'h2600, 16'h02A8};

   // ---------------- directed sequence ----------------
   initial begin
      int n, ref_cyc, e, sb, ob;
      rst_n = 1'b0; enable = 1'b1; sample_in = v_s[0]; pd = v_p[0];
      repeat (3) @(posedge clk);
      #1;
      check("rst_sync_n", a_sync_n, 1);
      check("rst_sclk", a_sclk, 1);
      check("rst_din", a_din, 0);
      check("rst_busy", a_busy, 0);
      check("rst_frame_done", a_done, 0);
      check("rst_overrun", a_ovr, 0);

      @(posedge clk); #1 rst_n = 1'b1;
      cycles_to_start(n);
      check("first_start_cycle", n, SD);

      // Streaming table; inputs change mid-frame and must not disturb it
      for (int i = 0; i < 7; i++) begin
         if (i > 0) wait_start(i + 1);
         if (i < 6) begin
            sample_in = v_s[i + 1]; pd = v_p[i + 1];
         end
         wait_end(i + 1);
         check($sformatf("frame%0d_word", i), a_word, v_w[i]);
         check($sformatf("frame%0d_nbits", i), a_nbits, 16);
         check($sformatf("frame%0d_sync_len", i), a_sync_len, 33 * CD);
         if (i > 0) check($sformatf("frame%0d_interval", i), a_start_cyc - a_prev_start_cyc, SD);
         if (i == 0) begin
            repeat (8) @(negedge clk);
            #1;
            check("frame0_busy_len", a_busy_len, 35 * CD);
            check("frame0_done_pulses", a_n_done, 1);
         end
      end
      check("stream_no_overrun", a_n_ovr, 0);

      // Enable dropped mid-frame: frame completes, then silence
      wait_start(8);
      repeat (10) @(posedge clk);
      #1 enable = 1'b0;
      wait_end(8);
      check("en_frame_word", a_word, 16'h02A8);
      check("en_frame_nbits", a_nbits, 16);
      ref_cyc = a_start_cyc;
      repeat (300) @(negedge clk);
      #1;
      check("en_off_no_start", a_n_start, 8);
      check("en_off_no_overrun", a_n_ovr, 0);
      enable = 1'b1;
      wait_start(9);
      check("en_on_tick_aligned", (a_start_cyc - ref_cyc) % SD, 0);

      // Reset mid-frame
      repeat (20) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_sync_n", a_sync_n, 1);
      check("midrst_sclk", a_sclk, 1);
      check("midrst_din", a_din, 0);
      check("midrst_busy", a_busy, 0);
      sample_in = 10'h123; pd = 2'b01;
      @(posedge clk); #1 rst_n = 1'b1;
      e = a_n_end;
      cycles_to_start(n);
      check("post_rst_start_cycle", n, SD);
      wait_end(e + 1);
      check("post_rst_word", a_word, 16'h1C8C);
      check("post_rst_nbits", a_nbits, 16);

      // Overrun instance: every second tick dropped, frames every 100 cycles
      repeat (200) @(negedge clk);
      #1;
      sb = b_n_start; ob = b_n_ovr;
      repeat (1000) @(negedge clk);
      #1;
      check("ovr_b_starts", b_n_start - sb, 10);
      check("ovr_b_pulses", b_n_ovr - ob, 10);
      check("ovr_b_interval", b_start_cyc - b_prev_start_cyc, 100);
      check("ovr_b_word", b_word, 16'h2D54);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
